// File: rtl/multicycle_seq.sv
// multicycle_seq: phase sequencer for the multi-cycle core.
// Walks FETCH/DECODE/EXECUTE/[MEMACCESS]/WRITEBACK, handshaking IM/DM wait states via *_ready,
// and registers ALU result/overflow, load data and a retired-instruction count.
// Optional feature: define MULTICYCLE_SEQ_BUS_TIMEOUT_EN to bound memory waits to TIMEOUT cycles
// and raise a sticky bus_error on expiry.
module multicycle_seq #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned IM_ADDR_W = 10,
    parameter int unsigned DM_ADDR_W = 12,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [IM_ADDR_W-1:0] pc_in,
    output logic                 IM_enable,
    output logic                 IM_read,
    output logic [IM_ADDR_W-1:0] IM_address,
    input  logic                 IM_ready,
    input  logic [DATA_W-1:0]    IM_data,
    output logic [DATA_W-1:0]    instruction,
    input  logic                 need_mem,
    input  logic                 mem_write,
    input  logic [DATA_W-1:0]    alu_result,
    input  logic                 alu_ovf_in,
    input  logic [DATA_W-1:0]    store_data,
    output logic                 DM_enable,
    output logic                 DM_read,
    output logic                 DM_write,
    output logic [DM_ADDR_W-1:0] DM_address,
    output logic [DATA_W-1:0]    DM_in,
    input  logic [DATA_W-1:0]    DM_out,
    input  logic                 DM_ready,
    output logic [DATA_W-1:0]    load_data,
    output logic [DATA_W-1:0]    alu_result_q,
    output logic                 alu_overflow,
    output logic                 enable_decode,
    output logic                 enable_execute,
    output logic                 enable_writeback,
    output logic                 busy,
    output logic [CNT_W-1:0]     instret,
    output logic                 bus_error
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecute,
        StMemaccess,
        StWriteback
    } state_e;

    state_e state_q, state_d;
    logic   wr_flag_q, wr_flag_d;
    logic   timeout;

`ifdef MULTICYCLE_SEQ_BUS_TIMEOUT_EN
    // Counter only needs to reach TIMEOUT-1; the TIMEOUT-th idle cycle is the expiry itself.
    localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [WaitW-1:0] wait_cnt_q;
    logic             bus_error_q;
    logic             req_wait;

    // A request cycle without ready; expiry when the wait budget is used up.
    always_comb begin
        req_wait = ((state_q == StFetch) && !IM_ready) ||
                   ((state_q == StMemaccess) && !DM_ready);
        timeout  = req_wait && (wait_cnt_q == WaitW'(TIMEOUT - 1));
    end

    // Wait counter (cleared on every state change) and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q  <= '0;
            bus_error_q <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                wait_cnt_q <= '0;
            end else if (req_wait) begin
                wait_cnt_q <= wait_cnt_q + WaitW'(1);
            end
            if (timeout) begin
                bus_error_q <= 1'b1;
            end
        end
    end

    assign bus_error = bus_error_q;
`else
    assign timeout   = 1'b0;
    assign bus_error = 1'b0;
`endif

    // Next-state decode; the store/load flag is captured from mem_write in EXECUTE.
    always_comb begin
        state_d   = state_q;
        wr_flag_d = wr_flag_q;
        unique case (state_q)
            StIdle: begin
                if (start && !bus_error) state_d = StFetch;
            end
            StFetch: begin
                if (IM_ready)     state_d = StDecode;
                else if (timeout) state_d = StIdle;
            end
            StDecode: begin
                state_d = StExecute;
            end
            StExecute: begin
                wr_flag_d = mem_write;
                state_d   = need_mem ? StMemaccess : StWriteback;
            end
            StMemaccess: begin
                if (DM_ready)     state_d = StWriteback;
                else if (timeout) state_d = StIdle;
            end
            StWriteback: begin
                state_d = start ? StFetch : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register plus registered strobes (decoded from next state) and datapath latches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= StIdle;
            wr_flag_q        <= 1'b0;
            IM_enable        <= 1'b0;
            IM_read          <= 1'b0;
            IM_address       <= '0;
            instruction      <= '0;
            DM_enable        <= 1'b0;
            DM_read          <= 1'b0;
            DM_write         <= 1'b0;
            DM_address       <= '0;
            DM_in            <= '0;
            load_data        <= '0;
            alu_result_q     <= '0;
            alu_overflow     <= 1'b0;
            enable_decode    <= 1'b0;
            enable_execute   <= 1'b0;
            enable_writeback <= 1'b0;
            busy             <= 1'b0;
            instret          <= '0;
        end else begin
            state_q          <= state_d;
            wr_flag_q        <= wr_flag_d;
            IM_enable        <= (state_d == StFetch);
            IM_read          <= (state_d == StFetch);
            DM_enable        <= (state_d == StMemaccess);
            DM_read          <= (state_d == StMemaccess) && !wr_flag_d;
            DM_write         <= (state_d == StMemaccess) && wr_flag_d;
            enable_decode    <= (state_d == StDecode);
            enable_execute   <= (state_d == StExecute);
            enable_writeback <= (state_d == StWriteback);
            busy             <= (state_d != StIdle);

            // Fetch address is frozen for the whole request.
            if ((state_d == StFetch) && (state_q != StFetch)) begin
                IM_address <= pc_in;
            end
            if ((state_q == StFetch) && IM_ready) begin
                instruction <= IM_data;
            end
            if (state_q == StExecute) begin
                alu_result_q <= alu_result;
                alu_overflow <= alu_ovf_in;
                DM_address   <= alu_result[DM_ADDR_W-1:0];
                DM_in        <= store_data;
            end
            if ((state_q == StMemaccess) && DM_ready && !wr_flag_q) begin
                load_data <= DM_out;
            end
            if (state_q == StWriteback) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_seq.sv
// tb_multicycle_seq: directed plus randomized checks of multicycle_seq against a phase-schedule model.
// Build with MULTICYCLE_SEQ_BUS_TIMEOUT_EN defined to also exercise the fetch timeout.
module tb_multicycle_seq;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned IM_ADDR_W = 10;
    localparam int unsigned DM_ADDR_W = 12;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned TIMEOUT   = 15;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [IM_ADDR_W-1:0] pc_in;
    logic                 IM_enable;
    logic                 IM_read;
    logic [IM_ADDR_W-1:0] IM_address;
    logic                 IM_ready;
    logic [DATA_W-1:0]    IM_data;
    logic [DATA_W-1:0]    instruction;
    logic                 need_mem;
    logic                 mem_write;
    logic [DATA_W-1:0]    alu_result;
    logic                 alu_ovf_in;
    logic [DATA_W-1:0]    store_data;
    logic                 DM_enable;
    logic                 DM_read;
    logic                 DM_write;
    logic [DM_ADDR_W-1:0] DM_address;
    logic [DATA_W-1:0]    DM_in;
    logic [DATA_W-1:0]    DM_out;
    logic                 DM_ready;
    logic [DATA_W-1:0]    load_data;
    logic [DATA_W-1:0]    alu_result_q;
    logic                 alu_overflow;
    logic                 enable_decode;
    logic                 enable_execute;
    logic                 enable_writeback;
    logic                 busy;
    logic [CNT_W-1:0]     instret;
    logic                 bus_error;

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_load;
    int unsigned model_cnt;

    multicycle_seq #(
        .DATA_W    (DATA_W),
        .IM_ADDR_W (IM_ADDR_W),
        .DM_ADDR_W (DM_ADDR_W),
        .CNT_W     (CNT_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .pc_in            (pc_in),
        .IM_enable        (IM_enable),
        .IM_read          (IM_read),
        .IM_address       (IM_address),
        .IM_ready         (IM_ready),
        .IM_data          (IM_data),
        .instruction      (instruction),
        .need_mem         (need_mem),
        .mem_write        (mem_write),
        .alu_result       (alu_result),
        .alu_ovf_in       (alu_ovf_in),
        .store_data       (store_data),
        .DM_enable        (DM_enable),
        .DM_read          (DM_read),
        .DM_write         (DM_write),
        .DM_address       (DM_address),
        .DM_in            (DM_in),
        .DM_out           (DM_out),
        .DM_ready         (DM_ready),
        .load_data        (load_data),
        .alu_result_q     (alu_result_q),
        .alu_overflow     (alu_overflow),
        .enable_decode    (enable_decode),
        .enable_execute   (enable_execute),
        .enable_writeback (enable_writeback),
        .busy             (busy),
        .instret          (instret),
        .bus_error        (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One instruction: the model is the phase schedule (im_wait+1 fetch, decode, execute,
    // dm_wait+1 memaccess if mem, writeback). Entered in IDLE or WRITEBACK; returns in WRITEBACK.
    task automatic run_instr(input int im_wait, input bit mem, input bit wr, input int dm_wait,
                             input logic [31:0] alu, input logic [31:0] sd, input bit cont);
        logic [IM_ADDR_W-1:0] pc;
        logic [31:0]          instr;
        logic [31:0]          dout;
        logic                 ovf;
        pc       = IM_ADDR_W'($urandom);
        instr    = $urandom;
        ovf      = 1'($urandom);
        pc_in    = pc;
        start    = 1'b1;
        IM_ready = 1'($urandom);
        step();
        for (int i = 0; i <= im_wait; i++) begin
            check("fetch_strobes", {IM_enable, IM_read, DM_enable, enable_decode, busy}, 5'b11001);
            check("fetch_addr", IM_address, pc);
            IM_data  = (i == im_wait) ? instr : $urandom;
            IM_ready = (i == im_wait);
            DM_ready = 1'($urandom);
            step();
        end
        IM_ready = 1'($urandom);
        check("decode_strobes", {IM_enable, enable_decode, enable_execute, DM_enable}, 4'b0100);
        check("instruction", instruction, instr);
        alu_result = alu;
        alu_ovf_in = ovf;
        store_data = sd;
        need_mem   = mem;
        mem_write  = wr;
        start      = cont;
        step();
        check("execute_strobes", {enable_decode, enable_execute, enable_writeback, DM_enable, busy},
              5'b01001);
        step();
        alu_result = $urandom;
        alu_ovf_in = 1'($urandom);
        store_data = $urandom;
        need_mem   = 1'($urandom);
        mem_write  = 1'($urandom);
        if (mem) begin
            for (int j = 0; j <= dm_wait; j++) begin
                check("mem_strobes", {DM_enable, DM_read, DM_write, IM_enable, enable_writeback},
                      {1'b1, !wr, wr, 2'b00});
                check("mem_addr", DM_address, alu[DM_ADDR_W-1:0]);
                check("mem_data", DM_in, sd);
                dout     = $urandom;
                DM_out   = dout;
                DM_ready = (j == dm_wait);
                IM_ready = 1'($urandom);
                if ((j == dm_wait) && !wr) exp_load = dout;
                step();
            end
        end
        DM_ready = 1'($urandom);
        IM_ready = 1'($urandom);
        DM_out   = $urandom;
        check("wb_strobes", {enable_writeback, enable_execute, DM_enable, IM_enable, busy, bus_error},
              6'b100010);
        check("alu_result_q", alu_result_q, alu);
        check("alu_overflow", alu_overflow, ovf);
        check("load_data", load_data, exp_load);
        check("instret_wb", instret, model_cnt);
        model_cnt = (model_cnt + 1) % (2 ** CNT_W);
    endtask

    task automatic finish_idle();
        step();
        check("idle_busy", {busy, IM_enable, DM_enable}, 3'b000);
        check("idle_instret", instret, model_cnt);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        exp_load   = '0;
        model_cnt  = 0;
        rst        = 1'b1;
        start      = 1'b0;
        pc_in      = '0;
        IM_ready   = 1'b0;
        IM_data    = '0;
        need_mem   = 1'b0;
        mem_write  = 1'b0;
        alu_result = '0;
        alu_ovf_in = 1'b0;
        store_data = '0;
        DM_out     = '0;
        DM_ready   = 1'b0;
        #1 rst = 1'b0;
        #2;
        check("reset_strobes", {IM_enable, IM_read, DM_enable, DM_read, DM_write, enable_decode,
              enable_execute, enable_writeback, busy, alu_overflow, bus_error}, 11'd0);
        check("reset_instret", instret, 0);
        check("reset_regs", {instruction, load_data}, 64'd0);
        check("reset_addr", {IM_address, DM_address, DM_in, alu_result_q}, 0);
        #9 rst = 1'b1;
        step();
        check("idle_no_start", busy, 1'b0);

        // ALU op, zero waits, start dropped during EXECUTE.
        run_instr(0, 1'b0, 1'b0, 0, $urandom, $urandom, 1'b0);
        finish_idle();
        // Load with 3 DM wait cycles.
        run_instr(0, 1'b1, 1'b0, 3, 32'h0000_0ABC, $urandom, 1'b0);
        finish_idle();
        // Store with IM and DM waits; load_data must hold.
        run_instr(1, 1'b1, 1'b1, 2, $urandom, 32'hDEAD_BEEF, 1'b0);
        finish_idle();

        // Reset asserted during MEMACCESS.
        pc_in      = 10'h055;
        IM_ready   = 1'b1;
        start      = 1'b1;
        need_mem   = 1'b1;
        mem_write  = 1'b0;
        alu_result = 32'h0000_0123;
        DM_ready   = 1'b0;
        step();
        step();
        step();
        step();
        check("pre_rst_mem", {DM_enable, DM_read, busy}, 3'b111);
        #1 rst = 1'b0;
        #1;
        check("rst_mid_strobes", {IM_enable, IM_read, DM_enable, DM_read, DM_write, enable_decode,
              enable_execute, enable_writeback, busy, alu_overflow, bus_error}, 11'd0);
        check("rst_mid_regs", {load_data, alu_result_q}, 64'd0);
        check("rst_mid_misc", {instret, DM_address, IM_address}, 0);
        start    = 1'b0;
        IM_ready = 1'b0;
        #1 rst = 1'b1;
        exp_load  = '0;
        model_cnt = 0;
        step();
        check("post_rst_idle", busy, 1'b0);
        run_instr(0, 1'b1, 1'b0, 1, $urandom, $urandom, 1'b0);
        finish_idle();

        // Randomized back-to-back traffic; enough retirements to wrap the counter.
        for (int k = 0; k < 300; k++) begin
            bit cont;
            cont = ($urandom_range(0, 7) != 0);
            run_instr($urandom_range(0, 3), 1'($urandom), 1'($urandom), $urandom_range(0, 3),
                      $urandom, $urandom, cont);
            if (!cont) finish_idle();
        end
        run_instr(0, 1'b0, 1'b0, 0, $urandom, $urandom, 1'b0);
        finish_idle();

`ifdef MULTICYCLE_SEQ_BUS_TIMEOUT_EN
        // IM never ready: request dropped after TIMEOUT fetch cycles, no retirement.
        IM_ready = 1'b0;
        start    = 1'b1;
        pc_in    = 10'h3A5;
        step();
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            check("to_fetch", {IM_enable, bus_error}, 2'b10);
            step();
        end
        check("to_bus_error", bus_error, 1'b1);
        check("to_idle", {busy, IM_enable, enable_writeback}, 3'b000);
        check("to_instret", instret, model_cnt);
        step();
        step();
        check("to_start_ignored", {busy, bus_error}, 2'b01);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
